// File: rtl/pci_arbiter.sv
// Four-device PCI bus arbiter: round-robin grants, one turnaround cycle between
// owners, and a watchdog that revokes a grant whose owner never starts a cycle.
module pci_arbiter #(
    parameter int GNT_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic       frame,
    input  logic       irdy,
    output logic [3:0] gnt,
    output logic [1:0] owner,
    output logic       bus_busy,
    output logic       timeout
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] BUSY  = 2'd2;
    localparam logic [1:0] TURN  = 2'd3;

    localparam logic [7:0] WD_LIMIT = 8'(GNT_TIMEOUT - 1);
    localparam logic [3:0] GNT_NONE = 4'b1111;

    logic [1:0] state;
    logic [1:0] last;
    logic [1:0] winner;
    logic [1:0] cand;
    logic [7:0] watchdog;
    logic       have_req;
    logic       bus_idle;
    logic       frame_asserted;

    // Floating or unknown shared lines must read as deasserted, hence case equality.
    assign frame_asserted = (frame === 1'b0);
    assign bus_idle       = (frame !== 1'b0) && (irdy !== 1'b0);

    // Round-robin search starting one past the most recently granted device.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        winner   = last;
        cand     = last;
        have_req = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            cand = last + 2'(i);
            if (!have_req && !req[cand]) begin
                winner   = cand;
                have_req = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
        if (!reset) begin
            state    <= IDLE;
            gnt      <= GNT_NONE;
            owner    <= 2'b00;
            last     <= 2'b11;
            watchdog <= 8'd0;
            timeout  <= 1'b0;
            bus_busy <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (have_req && bus_idle) begin
                        gnt      <= ~(4'b0001 << winner);
                        owner    <= winner;
                        watchdog <= 8'd0;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (frame_asserted) begin
                        state    <= BUSY;
                        bus_busy <= 1'b1;
                        last     <= owner;
                    end else if (req[owner]) begin
                        gnt   <= GNT_NONE;
                        state <= TURN;
                        last  <= owner;
                    end else if (watchdog == WD_LIMIT) begin
                        gnt     <= GNT_NONE;
                        timeout <= 1'b1;
                        state   <= TURN;
                        last    <= owner;
                    end else if (watchdog != 8'hFF) begin
                        watchdog <= watchdog + 8'd1;
                    end
                end
                BUSY: begin
                    // Bus release wins over a request drop; a dropped grant is not reissued mid-transaction.
                    if (bus_idle) begin
                        gnt      <= GNT_NONE;
                        state    <= TURN;
                        bus_busy <= 1'b0;
                    end else if (req[owner]) begin
                        gnt <= GNT_NONE;
                    end
                end
                TURN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pci_arbiter.sv
// Scoreboard bench for pci_arbiter: a cycle reference model predicts outputs,
// a monitor compares them, and directed scenarios cover the named sequences.
module tb_pci_arbiter;

    localparam int T = 16;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic       frame;
    logic       irdy;
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       bus_busy;
    logic       timeout;

    int errors = 0;
    int checks = 0;

    pci_arbiter #(.GNT_TIMEOUT(T)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .frame    (frame),
        .irdy     (irdy),
        .gnt      (gnt),
        .owner    (owner),
        .bus_busy (bus_busy),
        .timeout  (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        bit         known;
        logic [3:0] gnt;
        logic [1:0] owner;
        logic       busy;
        logic       tmo;
    } exp_t;

    exp_t sb_q[$];
    int   grant_log[$];

    // phase: 0 waiting for arbitration, 1 granted but no cycle yet,
    // 2 transaction in progress, 3 turnaround
    int m_phase = 0;
    int m_dev   = -1;
    int m_owner = 0;
    int m_last  = 3;
    int m_age   = 0;
    bit m_tmo   = 0;
    bit m_known = 0;

    always @(posedge clk) begin : model
        exp_t e;
        bit   idle;
        bit   found;
        idle  = (frame == 1'b1) && (irdy == 1'b1);
        found = 0;
        if (reset == 1'b0) begin
            m_known = 1;
            m_phase = 0;
            m_dev   = -1;
            m_owner = 0;
            m_last  = 3;
            m_age   = 0;
            m_tmo   = 0;
        end else begin
            m_tmo = 0;
            case (m_phase)
                0: if (idle) begin
                    for (int k = 1; k <= 4; k++) begin
                        int w;
                        w = (m_last + k) % 4;
                        if (!found && req[w] == 1'b0) begin
                            found   = 1;
                            m_dev   = w;
                            m_owner = w;
                            m_age   = 0;
                            m_phase = 1;
                        end
                    end
                end
                1: begin
                    if (frame == 1'b0) begin
                        m_phase = 2;
                        m_last  = m_owner;
                    end else if (req[m_owner] == 1'b1) begin
                        m_dev = -1; m_phase = 3; m_last = m_owner;
                    end else if (m_age == T - 1) begin
                        m_dev = -1; m_phase = 3; m_last = m_owner; m_tmo = 1;
                    end else if (m_age < 255) begin
                        m_age++;
                    end
                end
                2: begin
                    if (idle) begin
                        m_dev = -1; m_phase = 3;
                    end else if (req[m_owner] == 1'b1) begin
                        m_dev = -1;
                    end
                end
                default: m_phase = 0;
            endcase
        end
        e.known = m_known;
        e.gnt   = (m_dev < 0) ? 4'hF : ~(4'b0001 << m_dev);
        e.owner = 2'(m_owner);
        e.busy  = (m_phase == 2);
        e.tmo   = m_tmo;
        sb_q.push_back(e);
    end

    logic [3:0] prev_gnt = 4'hF;

    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        if (sb_q.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL scoreboard: no expected entry at t=%0t", $time);
        end else begin
            e = sb_q.pop_front();
            if (e.known) begin
                check("gnt",      int'(gnt),      int'(e.gnt));
                check("owner",    int'(owner),    int'(e.owner));
                check("bus_busy", int'(bus_busy), int'(e.busy));
                check("timeout",  int'(timeout),  int'(e.tmo));
                check("gnt_at_most_one_low", int'($countones(~gnt) <= 1), 1);
                if (prev_gnt != 4'hF && gnt != 4'hF)
                    check("gnt_gap_between_owners", int'(gnt), int'(prev_gnt));
                if (prev_gnt == 4'hF && gnt != 4'hF) begin
                    for (int k = 0; k < 4; k++)
                        if (gnt[k] == 1'b0) grant_log.push_back(k);
                end
                prev_gnt = gnt;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; req = 4'hF; frame = 1'b1; irdy = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_gnt",     int'(gnt),      4'hF);
        check("rst_owner",   int'(owner),    0);
        check("rst_busy",    int'(bus_busy), 0);
        check("rst_timeout", int'(timeout),  0);
        reset = 1'b1;
    endtask

    // Returns on the first negedge where some grant is visible.
    task automatic wait_grant(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (gnt == 4'hF && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (gnt == 4'hF) begin
            errors++;
            checks++;
            $display("FAIL %s: no grant within 40 clocks, gnt=%0h", name, gnt);
        end
    endtask

    task automatic transaction(input logic [3:0] req_after);
        wait_grant("txn_grant");
        frame = 1'b0; irdy = 1'b0;
        repeat (3) @(negedge clk);
        frame = 1'b1; irdy = 1'b1; req = req_after;
    endtask

    initial begin : global_guard
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int         cnt;
        int         len;
        logic [3:0] seg_req;
        logic       seg_frame;
        logic       seg_irdy;
        int         exp_order[5];
        exp_order = '{0, 1, 2, 3, 0};

        reset = 1'b0; req = 4'hF; frame = 1'b1; irdy = 1'b1;
        do_reset();

        // round-robin rotation with everyone requesting
        grant_log.delete();
        req = 4'b0000;
        for (int t = 0; t < 5; t++) transaction((t == 4) ? 4'hF : 4'h0);
        repeat (3) @(negedge clk);
        check("rr_grant_count", grant_log.size(), 5);
        for (int k = 0; k < 5; k++)
            if (k < grant_log.size()) check("rr_order", grant_log[k], exp_order[k]);

        // watchdog: device 2 never starts a cycle
        do_reset();
        req = 4'b1011;
        wait_grant("wd_grant");
        cnt = 0;
        while (gnt == 4'b1011 && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        check("wd_grant_cycles", cnt, T);
        check("wd_revoke_gnt",   int'(gnt),     4'hF);
        check("wd_timeout_high", int'(timeout), 1);
        @(negedge clk);
        check("wd_timeout_pulse", int'(timeout), 0);
        check("wd_gap_gnt",       int'(gnt),     4'hF);
        @(negedge clk);
        check("wd_regrant", int'(gnt), 4'b1011);
        req = 4'hF;
        repeat (3) @(negedge clk);

        // owner 1 in BUSY holds the bus until it goes idle
        do_reset();
        req = 4'b1101;
        wait_grant("busy1_grant");
        check("busy1_owner", int'(owner), 1);
        frame = 1'b0; irdy = 1'b0; req = 4'b0000;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("busy1_hold_gnt", int'(gnt),      4'b1101);
            check("busy1_hold_bb",  int'(bus_busy), 1);
            if (k == 2) frame = 1'b1;
        end
        irdy = 1'b1;
        @(negedge clk);
        check("busy1_turn_gnt", int'(gnt),      4'hF);
        check("busy1_turn_bb",  int'(bus_busy), 0);
        wait_grant("busy1_next");
        check("busy1_next_gnt", int'(gnt), 4'b1011);
        req = 4'hF;
        repeat (3) @(negedge clk);

        // owner 0 drops its request mid-transaction
        do_reset();
        req = 4'b1110;
        wait_grant("rel_grant");
        frame = 1'b0; irdy = 1'b0;
        @(negedge clk);
        check("rel_busy_gnt", int'(gnt), 4'b1110);
        req = 4'hF;
        @(negedge clk);
        check("rel_drop_gnt", int'(gnt),      4'hF);
        check("rel_drop_bb",  int'(bus_busy), 1);
        repeat (3) begin
            @(negedge clk);
            check("rel_still_busy", int'(bus_busy), 1);
        end
        frame = 1'b1; irdy = 1'b1;
        @(negedge clk);
        check("rel_idle_bb", int'(bus_busy), 0);

        // reset during BUSY with owner 3
        do_reset();
        req = 4'b0111;
        wait_grant("rstb_grant");
        check("rstb_gnt", int'(gnt), 4'b0111);
        frame = 1'b0; irdy = 1'b0;
        @(negedge clk);
        check("rstb_busy", int'(bus_busy), 1);
        req = 4'b0000; reset = 1'b0;
        @(negedge clk);
        check("rstb_gnt_clear", int'(gnt),      4'hF);
        check("rstb_bb_clear",  int'(bus_busy), 0);
        frame = 1'b1; irdy = 1'b1;
        @(negedge clk);
        check("rstb_no_grant_in_reset", int'(gnt), 4'hF);
        reset = 1'b1;
        @(negedge clk);
        check("rstb_first_grant", int'(gnt), 4'b1110);

        // randomized segments checked entirely by the scoreboard
        do_reset();
        for (int s = 0; s < 120; s++) begin
            len       = $urandom_range(3, 40);
            seg_req   = 4'($urandom);
            if ($urandom_range(0, 3) == 0) seg_req = 4'hF;
            seg_frame = ($urandom_range(0, 2) != 0);
            seg_irdy  = ($urandom_range(0, 2) != 0);
            for (int c = 0; c < len; c++) begin
                @(negedge clk);
                reset = ($urandom_range(0, 299) != 0);
                req   = seg_req;
                if ($urandom_range(0, 9) == 0) req = 4'($urandom);
                frame = seg_frame ^ ($urandom_range(0, 7) == 0);
                irdy  = seg_irdy ^ ($urandom_range(0, 7) == 0);
            end
        end

        reset = 1'b1; req = 4'hF; frame = 1'b1; irdy = 1'b1;
        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
